// File: rtl/boot_data_sink_if.sv
// Boot loader -> data sink bundle: loader word stream, instruction memory
// write port, CPU start/pop handshake and status flags.
interface boot_data_sink_if #(
  parameter int IMEM_ADDR_WIDTH = 14
);

  // Boot loader stream
  logic                       instr_ready;
  logic                       data_ready;
  logic [31:0]                content;
  logic                       program_loaded;

  // Instruction memory write port and load status
  logic                       imem_we;
  logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]                imem_wdata;
  logic [IMEM_ADDR_WIDTH:0]   instr_count;
  logic                       cpu_start;

  // CPU data pop handshake and FIFO status
  logic                       pop_req;
  logic                       pop_valid;
  logic [31:0]                pop_data;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       overflow;

  // Environment side: drives the loader stream and the CPU pop request
  modport master (
    output instr_ready, data_ready, content, program_loaded, pop_req,
    input  imem_we, imem_addr, imem_wdata, instr_count, cpu_start,
           pop_valid, pop_data, fifo_empty, fifo_full, overflow
  );

  // Sink side: consumes the stream, drives memory writes and status
  modport slave (
    input  instr_ready, data_ready, content, program_loaded, pop_req,
    output imem_we, imem_addr, imem_wdata, instr_count, cpu_start,
           pop_valid, pop_data, fifo_empty, fifo_full, overflow
  );

endinterface

// File: rtl/boot_data_sink.sv
// Boot data sink: writes instruction words to consecutive imem addresses,
// buffers data words in a circular FIFO drained by the CPU, and raises
// cpu_start once loading has ended and the last imem write has issued.
module boot_data_sink #(
  parameter int IMEM_ADDR_WIDTH = 14,
  parameter int FIFO_LOG2       = 10
) (
  input logic            clock,
  input logic            reset_n,
  boot_data_sink_if.slave bus
);

  localparam int                 FIFO_DEPTH      = 2 ** FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] FIFO_FULL_COUNT = (FIFO_LOG2 + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Instruction path
  // ---------------------------------------------------------------------
  state_t                     state_q;
  logic                       cpu_start_q;
  logic                       imem_we_q;
  logic [IMEM_ADDR_WIDTH-1:0] imem_addr_q;
  logic [31:0]                imem_wdata_q;
  logic [IMEM_ADDR_WIDTH:0]   instr_count_q;

  logic imem_full;
  logic instr_accept;
  logic instr_drop;

  // Memory is full once the count reaches 2**IMEM_ADDR_WIDTH (MSB set);
  // instruction pulses outside LOAD are ignored without flagging overflow.
  assign imem_full    = instr_count_q[IMEM_ADDR_WIDTH];
  assign instr_accept = bus.instr_ready && (state_q == ST_LOAD) && !imem_full;
  assign instr_drop   = bus.instr_ready && (state_q == ST_LOAD) && imem_full;

  // Registered imem write port: one-cycle-late write at the current count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      imem_we_q     <= 1'b0;
      imem_addr_q   <= '0;
      imem_wdata_q  <= '0;
      instr_count_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      imem_we_q <= instr_accept;
      if (instr_accept) begin
        imem_addr_q   <= instr_count_q[IMEM_ADDR_WIDTH-1:0];
        imem_wdata_q  <= bus.content;
        instr_count_q <= instr_count_q + (IMEM_ADDR_WIDTH + 1)'(1);
      end
    end
  end

  // Load sequencing FSM with registered cpu_start (high exactly in RUN)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_LOAD;
      cpu_start_q <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (bus.program_loaded) begin
            if (instr_accept) begin
              // A write is being launched this edge; let it issue first.
              state_q <= ST_DRAIN;
            end else begin
              // Nothing in flight: the drain phase would be empty.
              state_q     <= ST_RUN;
              cpu_start_q <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // The final write is on imem_we this cycle and no new ones can be
          // accepted, so the CPU may start from the next cycle on.
          state_q     <= ST_RUN;
          cpu_start_q <= 1'b1;
        end
        ST_RUN: begin
          state_q     <= ST_RUN;
          cpu_start_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_LOAD;
          cpu_start_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Data FIFO
  // ---------------------------------------------------------------------
  logic [31:0]          fifo_mem [FIFO_DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr_q;
  logic [FIFO_LOG2-1:0] rd_ptr_q;
  logic [FIFO_LOG2:0]   count_q;
  logic [FIFO_LOG2:0]   count_next;
  logic                 fifo_empty_q;
  logic                 fifo_full_q;
  logic                 pop_valid_q;
  logic [31:0]          pop_data_q;
  logic                 overflow_q;

  logic do_pop;
  logic do_push;
  logic push_drop;

  // Pop needs a word already stored (no bypass); a full FIFO still takes a
  // push when a pop frees the head slot in the same cycle.
  assign do_pop    = bus.pop_req && !fifo_empty_q;
  assign do_push   = bus.data_ready && (!fifo_full_q || do_pop);
  assign push_drop = bus.data_ready && fifo_full_q && !do_pop;

  // Occupancy after this cycle's push/pop
  always_comb begin
    // NOTE: default assignment first so no path leaves count_next unassigned
    // and no latch is inferred.
    count_next = count_q;
    case ({do_push, do_pop})
      2'b10:   count_next = count_q + (FIFO_LOG2 + 1)'(1);
      2'b01:   count_next = count_q - (FIFO_LOG2 + 1)'(1);
      default: count_next = count_q;
    endcase
  end

  // FIFO storage write
  // NOTE: the storage array is not reset; valid contents are defined by the
  // pointers and count, which are.
  always_ff @(posedge clock) begin
    if (do_push) begin
      fifo_mem[wr_ptr_q] <= bus.content;
    end
  end

  // Pointers, occupancy and registered empty/full flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fifo_empty_q <= 1'b1;
      fifo_full_q  <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + FIFO_LOG2'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_LOG2'(1);
      end
      count_q      <= count_next;
      fifo_empty_q <= (count_next == '0);
      fifo_full_q  <= (count_next == FIFO_FULL_COUNT);
    end
  end

  // Pop response: head word one cycle after an accepted pop, held otherwise
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      pop_valid_q <= do_pop;
      if (do_pop) begin
        pop_data_q <= fifo_mem[rd_ptr_q];
      end
    end
  end

  // Sticky drop flag for either imem or FIFO overflow
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (instr_drop || push_drop) begin
      overflow_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.imem_we     = imem_we_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.imem_wdata  = imem_wdata_q;
  assign bus.instr_count = instr_count_q;
  assign bus.cpu_start   = cpu_start_q;
  assign bus.pop_valid   = pop_valid_q;
  assign bus.pop_data    = pop_data_q;
  assign bus.fifo_empty  = fifo_empty_q;
  assign bus.fifo_full   = fifo_full_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_boot_data_sink.sv
// Self-checking bench for boot_data_sink with a small instance
// (4-word imem, 4-word FIFO). A queue-based reference model tracks the
// expected imem writes, FIFO contents, start condition and overflow.
module tb_boot_data_sink;

  localparam int IW         = 2;
  localparam int FL         = 2;
  localparam int DEPTH      = 4;
  localparam int IMEM_WORDS = 4;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  boot_data_sink_if #(.IMEM_ADDR_WIDTH(IW)) bus ();

  boot_data_sink #(
    .IMEM_ADDR_WIDTH(IW),
    .FIFO_LOG2      (FL)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  // Reference model state
  logic [31:0]   mq[$];
  int            m_icount;
  bit            m_loading;
  int            m_end_edge;
  int            m_last_wr;
  bit            m_ovf;
  logic [31:0]   m_last_pop;
  logic [IW-1:0] m_addr;
  logic [31:0]   m_wdata;
  bit            pl_level;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_icount   = 0;
    m_loading  = 1'b1;
    m_end_edge = 0;
    m_last_wr  = -10;
    m_ovf      = 1'b0;
    m_last_pop = '0;
    m_addr     = '0;
    m_wdata    = '0;
    pl_level   = 1'b0;
  endtask

  // Pulse reset_n low away from the clock edge; outputs must clear at once.
  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_imem_we",     64'(bus.imem_we),     64'(0));
    check("rst_imem_addr",   64'(bus.imem_addr),   64'(0));
    check("rst_imem_wdata",  64'(bus.imem_wdata),  64'(0));
    check("rst_instr_count", 64'(bus.instr_count), 64'(0));
    check("rst_cpu_start",   64'(bus.cpu_start),   64'(0));
    check("rst_pop_valid",   64'(bus.pop_valid),   64'(0));
    check("rst_pop_data",    64'(bus.pop_data),    64'(0));
    check("rst_fifo_empty",  64'(bus.fifo_empty),  64'(1));
    check("rst_fifo_full",   64'(bus.fifo_full),   64'(0));
    check("rst_overflow",    64'(bus.overflow),    64'(0));
    #2 reset_n = 1'b1;
    model_reset();
  endtask

  // One clock of stimulus; the model predicts the post-edge outputs.
  task automatic cycle(input bit ir, input bit dr, input bit pr, input logic [31:0] c);
    bit exp_we;
    bit exp_pv;
    bit do_pop;
    bit exp_start;
    bus.instr_ready    = ir;
    bus.data_ready     = dr;
    bus.pop_req        = pr;
    bus.content        = c;
    bus.program_loaded = pl_level;
    edge_n++;
    exp_we = 1'b0;
    exp_pv = 1'b0;
    if (ir && m_loading) begin
      if (m_icount < IMEM_WORDS) begin
        exp_we    = 1'b1;
        m_addr    = IW'(m_icount);
        m_wdata   = c;
        m_icount++;
        m_last_wr = edge_n;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (pl_level && m_loading) begin
      m_loading  = 1'b0;
      m_end_edge = edge_n;
    end
    do_pop = pr && (mq.size() != 0);
    if (do_pop) begin
      exp_pv     = 1'b1;
      m_last_pop = mq.pop_front();
    end
    if (dr) begin
      if (mq.size() < DEPTH) mq.push_back(c);
      else m_ovf = 1'b1;
    end
    // Start is allowed once loading ended and one cycle after the last write
    exp_start = !m_loading && (edge_n >= m_end_edge) && (edge_n >= m_last_wr + 1);

    @(posedge clock);
    #1;
    bus.instr_ready = 1'b0;
    bus.data_ready  = 1'b0;
    bus.pop_req     = 1'b0;

    check("imem_we",     64'(bus.imem_we),     64'(exp_we));
    check("imem_addr",   64'(bus.imem_addr),   64'(m_addr));
    check("imem_wdata",  64'(bus.imem_wdata),  64'(m_wdata));
    check("instr_count", 64'(bus.instr_count), 64'(m_icount));
    check("cpu_start",   64'(bus.cpu_start),   64'(exp_start));
    check("pop_valid",   64'(bus.pop_valid),   64'(exp_pv));
    check("pop_data",    64'(bus.pop_data),    64'(m_last_pop));
    check("fifo_empty",  64'(bus.fifo_empty),  64'(mq.size() == 0));
    check("fifo_full",   64'(bus.fifo_full),   64'(mq.size() == DEPTH));
    check("overflow",    64'(bus.overflow),    64'(m_ovf));
  endtask

  initial begin
    bus.instr_ready    = 1'b0;
    bus.data_ready     = 1'b0;
    bus.pop_req        = 1'b0;
    bus.content        = '0;
    bus.program_loaded = 1'b0;
    reset_n            = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    async_reset();

    // Three instructions two cycles apart, then program_loaded
    cycle(1'b1, 1'b0, 1'b0, 32'h11);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h22);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h33);
    pl_level = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("count_after_three", 64'(bus.instr_count), 64'(3));
    check("start_after_last_write", 64'(bus.cpu_start), 64'(1));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    // Instruction after RUN: ignored, no overflow
    cycle(1'b1, 1'b0, 1'b0, 32'hEE);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);

    // Reset mid-load, then overflow the 4-word imem
    async_reset();
    cycle(1'b1, 1'b0, 1'b0, 32'h55);
    cycle(1'b1, 1'b0, 1'b0, 32'h66);
    async_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'h70 + 32'(i));
    check("imem_overflow", 64'(bus.overflow), 64'(1));
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    // program_loaded in the same cycle as an accepted instruction
    async_reset();
    cycle(1'b1, 1'b0, 1'b0, 32'h81);
    pl_level = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 32'h82);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);

    // FIFO fill, drop, drain in order
    async_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 32'hA0 + 32'(i));
    check("fifo_full_after_four", 64'(bus.fifo_full), 64'(1));
    cycle(1'b0, 1'b1, 1'b0, 32'hA4);
    check("fifo_overflow", 64'(bus.overflow), 64'(1));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 32'h0);
    check("last_pop_a3", 64'(bus.pop_data), 64'(32'hA3));
    cycle(1'b0, 1'b0, 1'b1, 32'h0);

    // Push and pop on empty FIFO: no bypass
    async_reset();
    cycle(1'b0, 1'b1, 1'b1, 32'hB0);
    check("no_bypass_valid", 64'(bus.pop_valid), 64'(0));
    cycle(1'b0, 1'b0, 1'b1, 32'h0);
    check("pop_b0", 64'(bus.pop_data), 64'(32'hB0));

    // Full FIFO with simultaneous push and pop, then wrap-around drain
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 1'b0, 32'hC0 + 32'(i));
    cycle(1'b0, 1'b1, 1'b1, 32'hC0);
    check("full_push_pop_head", 64'(bus.pop_data), 64'(32'hC1));
    check("full_push_pop_stays_full", 64'(bus.fifo_full), 64'(1));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 32'h0);
    check("c0_emerges_last", 64'(bus.pop_data), 64'(32'hC0));

    // Randomized mix of instruction, push and pop traffic
    async_reset();
    for (int i = 0; i < 300; i++) begin
      if (i == 150) pl_level = 1'b1;
      cycle(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
